l2_cache: RTL and testbench
===========================

L2_CACHE -- requirements
Module: L2_cache

Interface
REQ-001 SHALL have parameter n, default 32, data word width in bits.
REQ-002 SHALL have parameter block_size, default 16, words per block streamed on refill.
REQ-003 SHALL have parameter addr_w, default 15, word-address width; storage depth is 2**addr_w words.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port L2_read_request  input  1  L1 requests a block refill; held high until the refill completes.
REQ-007 SHALL have port L2_write_request  input  1  L1 write-through of one word.
REQ-008 SHALL have port L2_word_address  input  addr_w  word address; bits [addr_w-1:4] select the block on reads.
REQ-009 SHALL have port L2_write_word  input  n  write-through data.
REQ-010 SHALL have port L2_read_word  output  n  registered refill data word.
REQ-011 SHALL have port L2_busy  output  1  stalls L1 while high.
REQ-012 SHALL have port flush  output  1  one-cycle invalidate-all command to L1.
REQ-013 SHALL have port snoop_inv  input  1  external invalidate request (present only with L2_FLUSH_EN).

Function
REQ-014 SHALL implement states IDLE, FETCH, STREAM, DRAIN, FLUSH_ST.
REQ-015 IDLE: SHALL service pending flush first (L2_FLUSH_EN only), then L2_write_request, then L2_read_request; write beats read when both are high.
REQ-016 Write: at the edge in IDLE with L2_write_request=1, SHALL store L2_write_word at L2_word_address; state stays IDLE; L2_busy stays low; latency 1 cycle.
REQ-017 L2_busy SHALL be combinational: 1 when (IDLE and L2_read_request=1 and no write/flush is taken) or state is FETCH or FLUSH_ST; otherwise 0.
REQ-018 Read start: at the edge in IDLE with the read taken, SHALL latch block base = {L2_word_address[addr_w-1:4], 4'b0}, clear word pointer, load L2_read_word <= mem[base], and go to FETCH.
REQ-019 FETCH: SHALL last one cycle with L2_busy=1, then go to STREAM; L2_read_word holds word 0.
REQ-020 STREAM: L2_busy=0; at each edge SHALL increment the pointer and load L2_read_word <= mem[base+pointer+1], so word k is valid during the k-th STREAM cycle.
REQ-021 STREAM SHALL last exactly block_size cycles (pointer 0..15, 4-bit wrap not permitted), then go to DRAIN.
REQ-022 DRAIN: SHALL hold L2_read_word and return to IDLE only when L2_read_request=0, so a still-high request never restarts the refill.
REQ-023 L2_read_request dropping during FETCH or STREAM SHALL abort to IDLE at the next edge.
REQ-024 L2_write_request outside IDLE SHALL be ignored (L1 is stalled or busy; it never issues it there).

Reset
REQ-025 While reset=0: state IDLE, L2_read_word=0, flush=0, pointer=0, pending flush cleared; storage contents are not reset.
REQ-026 Reset asserted mid-STREAM SHALL abort immediately; L2_busy=0 during reset.

Configuration
REQ-027 With macro L2_FLUSH_EN defined: port snoop_inv exists; a snoop_inv pulse in any state SHALL set a pending flag; in IDLE a pending flag SHALL take FLUSH_ST for one cycle with flush=1 and L2_busy=1, clear the flag, then return to IDLE.
REQ-028 With L2_FLUSH_EN undefined: snoop_inv is absent, FLUSH_ST is unreachable, flush is tied to 0.

Verification
REQ-029 Write addr 0x0123 data 0xDEADBEEF, then read block 0x012x -> word 3 of STREAM = 0xDEADBEEF; L2_busy low during write.
REQ-030 Preload mem[0x40+k]=k+100; read request addr 0x0047 -> L2_busy high 1 cycle (FETCH), then 16 STREAM cycles with L2_read_word = 100..115 in order, L2_busy low.
REQ-031 Hold L2_read_request high 5 cycles after STREAM ends -> state DRAIN, no second FETCH, L2_busy stays 0.
REQ-032 Simultaneous read and write requests in IDLE -> write committed first, L2_busy=0 that cycle, read FETCH starts next cycle.
REQ-033 Assert reset=0 at STREAM word 7 -> L2_read_word=0, L2_busy=0 at once; after release, new request streams from word 0.
REQ-034 L2_FLUSH_EN: snoop_inv pulse during STREAM word 4 -> stream completes unchanged; after DRAIN->IDLE, flush=1 and L2_busy=1 for exactly one cycle.

Source files
------------

// File: rtl/l2_cache.sv
// ---------------------------------------------------------------------------
// l2_cache -- second-level word store with block-refill streaming to L1.
//
// The L1 writes through one word at a time and requests whole-block refills.
// A refill spends one stalled cycle (FETCH) loading word 0. It then streams
// block_size words, one per cycle, with L2_busy low (STREAM). It then parks
// in DRAIN until L1 drops its request, so a request left high cannot start
// a second refill.
//
// Optional feature (macro L2_FLUSH_EN): an external snoop_inv pulse in any
// state is remembered. The next time the block is idle, it sends L1 a
// one-cycle flush command (FLUSH_ST) with L2_busy high. Without the macro,
// snoop_inv does not exist and flush is tied low.
//
// Ports:
//   clk               single clock, rising edge
//   reset             asynchronous, active-low reset
//   L2_read_request   L1 block refill request, held high until done
//   L2_write_request  L1 write-through of one word (honoured only in IDLE)
//   L2_word_address   word address; [addr_w-1:4] selects the block on reads
//   L2_write_word     write-through data
//   snoop_inv         external invalidate pulse (L2_FLUSH_EN only)
//   L2_read_word      registered refill data word
//   L2_busy           combinational stall to L1
//   flush             one-cycle invalidate-all command to L1
// ---------------------------------------------------------------------------
module l2_cache #(
  parameter int n          = 32,
  parameter int block_size = 16,
  parameter int addr_w     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              L2_read_request,
  input  logic              L2_write_request,
  input  logic [addr_w-1:0] L2_word_address,
  input  logic [n-1:0]      L2_write_word,
`ifdef L2_FLUSH_EN
  input  logic              snoop_inv,
`endif
  output logic [n-1:0]      L2_read_word,
  output logic              L2_busy,
  output logic              flush
);

  // One spare bit so the pointer can never wrap inside the block.
  localparam int ptr_w = $clog2(block_size) + 1;

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, DRAIN, FLUSH_ST} state_t;

  state_t            state, state_nxt;
  logic [addr_w-1:0] base;
  logic [ptr_w-1:0]  ptr;
  logic [addr_w-1:0] rd_base;
  logic [addr_w-1:0] rd_next;
  logic              take_flush, take_write, take_read, last_word;

  logic [n-1:0] mem [0:(2**addr_w)-1];

  assign rd_base = {L2_word_address[addr_w-1:4], 4'b0};
  assign rd_next = base + addr_w'(ptr) + addr_w'(1);

`ifdef L2_FLUSH_EN
  logic pending;

  assign take_flush = (state == IDLE) && pending;
  assign flush      = (state == FLUSH_ST);

  // A new pulse wins over the clear, so a snoop that lands on the cycle the
  // flush is taken is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= 1'b0;
    else        pending <= snoop_inv | (pending & ~take_flush);
  end
`else
  assign take_flush = 1'b0;
  assign flush      = 1'b0;
`endif

  // IDLE priority: pending flush, then write, then read.
  assign take_write = (state == IDLE) && !take_flush && L2_write_request;
  assign take_read  = (state == IDLE) && !take_flush && !L2_write_request &&
                      L2_read_request;
  assign last_word  = (ptr == ptr_w'(block_size - 1));

  // Busy is forced low while reset is asserted, even if L1 holds a request.
  assign L2_busy = reset && (take_read || state == FETCH || state == FLUSH_ST);

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on the paths that do not assign it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take_flush)            state_nxt = FLUSH_ST;
                else if (take_read)        state_nxt = FETCH;
      FETCH:    if (!L2_read_request)      state_nxt = IDLE;
                else                       state_nxt = STREAM;
      STREAM:   if (!L2_read_request)      state_nxt = IDLE;
                else if (last_word)        state_nxt = DRAIN;
      DRAIN:    if (!L2_read_request)      state_nxt = IDLE;
      FLUSH_ST:                            state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      base         <= '0;
      ptr          <= '0;
      L2_read_word <= '0;
    end else begin
      state <= state_nxt;
      if (take_read) begin
        base         <= rd_base;
        ptr          <= '0;
        L2_read_word <= mem[rd_base];
      end else if (state == STREAM && L2_read_request && !last_word) begin
        // Word k+1 is loaded at the edge ending STREAM cycle k. The last word
        // is held into DRAIN.
        ptr          <= ptr + ptr_w'(1);
        L2_read_word <= mem[rd_next];
      end
    end
  end

  // NOTE: the storage array has no reset; clearing 2**addr_w words is not
  // wanted, and its contents are only meaningful after being written.
  always_ff @(posedge clk) begin
    if (take_write) mem[L2_word_address] <= L2_write_word;
  end

endmodule

// File: tb/tb_l2_cache.sv
// ---------------------------------------------------------------------------
// tb_l2_cache -- directed self-checking bench for l2_cache (default params).
// Inputs change 1 time unit after a rising edge. Outputs are checked 1 time
// unit after the inputs settle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_l2_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [14:0] addr;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic        busy;
  logic        flush;
`ifdef L2_FLUSH_EN
  logic        snoop;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l2_cache dut (
    .clk              (clk),
    .reset            (reset),
    .L2_read_request  (rd),
    .L2_write_request (wr),
    .L2_word_address  (addr),
    .L2_write_word    (wdata),
`ifdef L2_FLUSH_EN
    .snoop_inv        (snoop),
`endif
    .L2_read_word     (rword),
    .L2_busy          (busy),
    .flush            (flush)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
`ifdef L2_FLUSH_EN
    snoop = 1'b0;
`endif
    #12;
    // Reset state
    check("reset_rword", rword, 32'h0);
    check("reset_busy",  {31'b0, busy},  32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);
    rd = 1'b1; #1;
    check("reset_busy_with_req", {31'b0, busy}, 32'h0);
    rd = 1'b0;
    cyc();
    reset = 1'b1;
    #1;

    // Write-through, then read it back at word 3 of the block
    wr = 1'b1; addr = 15'h0123; wdata = 32'hDEADBEEF; #1;
    check("write_busy_low", {31'b0, busy}, 32'h0);
    cyc();
    wr = 1'b0; rd = 1'b1; addr = 15'h0125; #1;
    check("rd_idle_busy", {31'b0, busy}, 32'h1);
    cyc();                                   // FETCH
    check("rd_fetch_busy", {31'b0, busy}, 32'h1);
    cyc();                                   // STREAM word 0
    check("rd_stream_busy", {31'b0, busy}, 32'h0);
    cyc(); cyc(); cyc();                     // STREAM word 3
    check("wt_word3", rword, 32'hDEADBEEF);
    rd = 1'b0;
    cyc();                                   // abort to IDLE
    check("abort_stream_busy", {31'b0, busy}, 32'h0);

    // Preload mem[0x40+k] = k+100
    for (int k = 0; k < 16; k++) begin
      wr = 1'b1; addr = 15'h0040 + 15'(k); wdata = 32'(k + 100);
      cyc();
    end
    wr = 1'b0;

    // Refill of block 0x004x
    rd = 1'b1; addr = 15'h0047; #1;
    check("blk_idle_busy", {31'b0, busy}, 32'h1);
    cyc();
    check("blk_fetch_busy", {31'b0, busy}, 32'h1);
    check("blk_fetch_word0", rword, 32'd100);
    cyc();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blk_word%0d", k), rword, 32'(k + 100));
      check($sformatf("blk_busy%0d", k), {31'b0, busy}, 32'h0);
      cyc();
    end
    // DRAIN with the request still high
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain_busy%0d", k), {31'b0, busy}, 32'h0);
      check($sformatf("drain_word%0d", k), rword, 32'd115);
      cyc();
    end
    rd = 1'b0;
    cyc();
    check("drain_exit_busy", {31'b0, busy}, 32'h0);

    // Simultaneous read and write: the write goes first
    rd = 1'b1; wr = 1'b1; addr = 15'h0048; wdata = 32'h11111111; #1;
    check("rw_busy_low", {31'b0, busy}, 32'h0);
    cyc();
    wr = 1'b0; #1;
    check("rw_read_taken", {31'b0, busy}, 32'h1);
    cyc();
    check("rw_fetch_busy", {31'b0, busy}, 32'h1);
    check("rw_fetch_word0", rword, 32'd100);
    cyc();                                   // STREAM word 0
    for (int k = 0; k < 7; k++) cyc();       // STREAM word 7
    check("rw_word7", rword, 32'd107);

    // Reset mid-stream
    reset = 1'b0; #1;
    check("midrst_rword", rword, 32'h0);
    check("midrst_busy",  {31'b0, busy}, 32'h0);
    cyc();
    reset = 1'b1; #1;
    check("postrst_busy", {31'b0, busy}, 32'h1);
    cyc();
    check("postrst_fetch_word0", rword, 32'd100);
    cyc();
    check("postrst_stream_word0", rword, 32'd100);
    for (int k = 0; k < 8; k++) cyc();
    check("postrst_word8", rword, 32'h11111111);
    rd = 1'b0;
    cyc();
    check("postrst_idle_busy", {31'b0, busy}, 32'h0);

    // Request dropped during FETCH
    rd = 1'b1; addr = 15'h0047;
    cyc();
    rd = 1'b0; #1;
    check("abort_fetch_busy", {31'b0, busy}, 32'h1);
    cyc();
    check("abort_fetch_idle", {31'b0, busy}, 32'h0);
    check("no_flush", {31'b0, flush}, 32'h0);

`ifdef L2_FLUSH_EN
    // Snoop during STREAM word 4: stream unaffected, flush after DRAIN
    rd = 1'b1; addr = 15'h0040;
    cyc(); cyc();                            // STREAM word 0
    for (int k = 0; k < 4; k++) cyc();       // STREAM word 4
    snoop = 1'b1;
    cyc();
    snoop = 1'b0; #1;
    for (int k = 5; k < 16; k++) begin
      check($sformatf("snp_word%0d", k), rword, (k == 8) ? 32'h11111111 : 32'(k + 100));
      check($sformatf("snp_flush%0d", k), {31'b0, flush}, 32'h0);
      cyc();
    end
    check("snp_drain_busy", {31'b0, busy}, 32'h0);
    rd = 1'b0;
    cyc();                                   // IDLE, flush pending
    check("snp_idle_flush", {31'b0, flush}, 32'h0);
    cyc();                                   // FLUSH_ST
    check("snp_flush_hi", {31'b0, flush}, 32'h1);
    check("snp_flush_busy", {31'b0, busy}, 32'h1);
    cyc();
    check("snp_flush_lo", {31'b0, flush}, 32'h0);
    check("snp_after_busy", {31'b0, busy}, 32'h0);
    cyc();
    check("snp_once", {31'b0, flush}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
